// File: rtl/screen_ctrl.sv
// screen_ctrl: menu/game screen sequencer between the keyboard decoder and
// the VGA drawing pipeline.
//   - Key filter: a code becomes key_stable after STABLE_CYCLES identical
//     samples; codes 10..15 are folded to "released" before filtering.
//   - Press events: released -> valid code on key_stable, only once armed
//     (a stable release has been seen since reset).
//   - MENU/GAME/PAUSE logical state machine. Its state is latched into
//     screen/bg_color only on frame_tick, so one frame never shows two screens.
// Optional feature macro: SCREEN_CTRL_PAUSE_EN (esc in GAME enters PAUSE;
// when undefined, esc in GAME returns straight to MENU and PAUSE is unused).
// state_dbg mirrors the logical (not yet displayed) state for observation.
module screen_ctrl #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic        frame_tick,
    output logic [1:0]  screen,
    output logic [1:0]  level,
    output logic [11:0] bg_color,
    output logic        game_start,
    output logic        move_up,
    output logic        move_down,
    output logic        move_left,
    output logic        move_right,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        MENU  = 2'b00,
        GAME  = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [7:0]  STABLE_N  = 8'(STABLE_CYCLES);
    localparam logic [3:0]  KEY_REL   = 4'd0;
    localparam logic [3:0]  KEY_A     = 4'd1;
    localparam logic [3:0]  KEY_S     = 4'd2;
    localparam logic [3:0]  KEY_W     = 4'd3;
    localparam logic [3:0]  KEY_D     = 4'd4;
    localparam logic [3:0]  KEY_ESC   = 4'd9;
    localparam logic [11:0] COL_MENU  = 12'haaa;
    localparam logic [11:0] COL_GAME  = 12'h3aa;
    localparam logic [11:0] COL_PAUSE = 12'h555;

    logic [3:0] key_norm;   // decoder code with 10..15 folded to released
    logic [3:0] cand;       // code currently being timed by the filter
    logic [7:0] cnt;        // identical samples of cand seen so far (saturating)
    logic [3:0] key_stable; // filtered key code
    logic       armed;      // a stable release has been accepted since reset
    logic       evt;        // one-cycle press event
    logic [3:0] evt_code;   // code belonging to evt
    state_t     st;         // logical state, changes only on events

    function automatic logic [11:0] color_of(input state_t s);
        case (s)
            GAME:    color_of = COL_GAME;
            PAUSE:   color_of = COL_PAUSE;
            default: color_of = COL_MENU;
        endcase
    endfunction

    assign key_norm  = (key > 4'd9) ? KEY_REL : key;
    assign state_dbg = st;

    // Glitch filter, arming and press-event detection.
    // cnt == STABLE_N means the previous STABLE_CYCLES samples all equalled
    // cand, so cand is accepted on this edge and may raise an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand       <= KEY_REL;
            cnt        <= 8'd0;
            key_stable <= KEY_REL;
            armed      <= 1'b0;
            evt        <= 1'b0;
            evt_code   <= KEY_REL;
        end else begin
            evt <= 1'b0;
            if (key_norm == cand) begin
                if (cnt != STABLE_N) begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cand <= key_norm;
                cnt  <= 8'd1;
            end
            if (cnt == STABLE_N) begin
                key_stable <= cand;
                if (cand == KEY_REL) begin
                    armed <= 1'b1;
                end
                if (armed && key_stable == KEY_REL && cand != KEY_REL) begin
                    evt      <= 1'b1;
                    evt_code <= cand;
                end
            end
        end
    end

    // Logical state machine, registered pulses and frame-aligned display.
    // The tick commits the state held before this edge's event.
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= MENU;
            screen     <= MENU;
            level      <= 2'd0;
            bg_color   <= COL_MENU;
            game_start <= 1'b0;
            move_up    <= 1'b0;
            move_down  <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
        end else begin
            game_start <= 1'b0;
            move_up    <= 1'b0;
            move_down  <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            if (frame_tick) begin
                screen   <= st;
                bg_color <= color_of(st);
            end
            if (evt) begin
                case (st)
                    MENU: begin
                        if (evt_code >= 4'd5 && evt_code <= 4'd8) begin
                            // codes 5..8 map to levels 0..3
                            level      <= evt_code[1:0] - 2'd1;
                            st         <= GAME;
                            game_start <= 1'b1;
                        end
                    end
                    GAME: begin
                        case (evt_code)
                            KEY_W:   move_up    <= 1'b1;
                            KEY_S:   move_down  <= 1'b1;
                            KEY_A:   move_left  <= 1'b1;
                            KEY_D:   move_right <= 1'b1;
`ifdef SCREEN_CTRL_PAUSE_EN
                            KEY_ESC: st         <= PAUSE;
`else
                            KEY_ESC: st         <= MENU;
`endif
                            default: ;
                        endcase
                    end
                    PAUSE: begin
                        st <= (evt_code == KEY_ESC) ? MENU : GAME;
                    end
                    default: st <= MENU;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_screen_ctrl.sv
// tb_screen_ctrl: directed scenarios followed by randomized key/tick traffic,
// every cycle checked against a window-based behavioural model of screen_ctrl.
module tb_screen_ctrl;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key = 4'd0;
    logic        frame_tick = 1'b0;
    logic [1:0]  screen;
    logic [1:0]  level;
    logic [11:0] bg_color;
    logic        game_start;
    logic        move_up;
    logic        move_down;
    logic        move_left;
    logic        move_right;
    logic [1:0]  state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // clock
    always #5 clk = ~clk;

    screen_ctrl #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .frame_tick (frame_tick),
        .screen     (screen),
        .level      (level),
        .bg_color   (bg_color),
        .game_start (game_start),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .state_dbg  (state_dbg)
    );

    // ---------------- reference model ----------------
    int hist[$];        // last S normalized samples, oldest first
    int m_stable, m_armed, m_evt, m_code;
    int m_st, m_level, m_screen;
    logic [11:0] m_bg;
    logic [4:0]  m_pulse; // {game_start, up, down, left, right}

    // pulse counters observed from the DUT, for directed scenario checks
    int c_gs, c_up, c_down, c_left, c_right;

    function automatic logic [11:0] color_ref(input int s);
        if (s == 1) return 12'h3aa;
        if (s == 2) return 12'h555;
        return 12'haaa;
    endfunction

    task automatic model_edge(input int k, input bit t, input bit r);
        int kn, v, new_evt;
        bit same;
        if (r) begin
            hist.delete();
            m_stable = 0; m_armed = 0; m_evt = 0; m_code = 0;
            m_st = 0; m_level = 0; m_screen = 0; m_bg = 12'haaa; m_pulse = '0;
            return;
        end
        kn = (k > 9) ? 0 : k;
        m_pulse = '0;
        if (t) begin
            m_screen = m_st;
            m_bg     = color_ref(m_st);
        end
        if (m_evt != 0) begin
            if (m_st == 0) begin
                if (m_code >= 5 && m_code <= 8) begin
                    m_level = m_code - 5; m_st = 1; m_pulse[4] = 1'b1;
                end
            end else if (m_st == 1) begin
                if (m_code == 3) m_pulse[3] = 1'b1;
                if (m_code == 2) m_pulse[2] = 1'b1;
                if (m_code == 1) m_pulse[1] = 1'b1;
                if (m_code == 4) m_pulse[0] = 1'b1;
`ifdef SCREEN_CTRL_PAUSE_EN
                if (m_code == 9) m_st = 2;
`else
                if (m_code == 9) m_st = 0;
`endif
            end else begin
                m_st = (m_code == 9) ? 0 : 1;
            end
        end
        new_evt = 0;
        v = 0;
        if (hist.size() == S) begin
            v = hist[0];
            same = 1;
            foreach (hist[i]) if (hist[i] != v) same = 0;
            if (same) begin
                if (m_armed != 0 && m_stable == 0 && v != 0) new_evt = 1;
                if (v == 0) m_armed = 1;
                m_stable = v;
            end
        end
        hist.push_back(kn);
        if (hist.size() > S) void'(hist.pop_front());
        m_evt = new_evt;
        if (new_evt != 0) m_code = v;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("screen",   12'(screen),    12'(m_screen));
        chk("level",    12'(level),     12'(m_level));
        chk("bg_color", bg_color,       m_bg);
        chk("state",    12'(state_dbg), 12'(m_st));
        chk("pulses",   12'({game_start, move_up, move_down, move_left, move_right}), 12'(m_pulse));
        c_gs    += int'(game_start);
        c_up    += int'(move_up);
        c_down  += int'(move_down);
        c_left  += int'(move_left);
        c_right += int'(move_right);
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic [3:0] k, input logic t, input logic r);
        key = k; frame_tick = t; rst = r;
        @(posedge clk);
        model_edge(int'(k), t, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input logic [3:0] k, input int n);
        repeat (n) cyc(k, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cyc(key, 1'b1, 1'b0);
    endtask

    task automatic to_menu();
`ifdef SCREEN_CTRL_PAUSE_EN
        run(4'd9, 6); run(4'd0, 6);
`endif
        run(4'd9, 6); run(4'd0, 6);
        tick();
    endtask

    initial begin
        int b0, b1, b2;
        int code, len;
        bit t;
        c_gs = 0; c_up = 0; c_down = 0; c_left = 0; c_right = 0;

        // reset with digit held, then keep holding: no start
        repeat (3) cyc(4'd5, 1'b0, 1'b1);
        chk("rst_screen", 12'(screen), 12'h0);
        chk("rst_bg", bg_color, 12'haaa);
        run(4'd5, 10); tick(); run(4'd5, 9);
        chk("held_no_start", 12'(c_gs), 12'd0);
        chk("held_screen", 12'(screen), 12'h0);

        // release, then digit 2: level 1, GAME on next tick
        run(4'd0, 4); run(4'd6, 8); tick();
        chk("arm_start_cnt", 12'(c_gs), 12'd1);
        chk("arm_screen", 12'(screen), 12'h1);
        chk("arm_level", 12'(level), 12'h1);
        chk("arm_bg", bg_color, 12'h3aa);
        run(4'd0, 6);

        // glitch filter
        b0 = c_up;
        run(4'd3, 3); run(4'd0, 6);
        chk("glitch_short", 12'(c_up - b0), 12'd0);
        run(4'd3, 4); run(4'd0, 6);
        chk("glitch_exact", 12'(c_up - b0), 12'd1);
        run(4'd3, 100); run(4'd0, 6);
        chk("glitch_hold", 12'(c_up - b0), 12'd2);

        // code change without release; 10..15 act as released
        b0 = c_left; b1 = c_right; b2 = c_down;
        run(4'd1, 6); run(4'd4, 6); run(4'd0, 6);
        chk("chg_left", 12'(c_left - b0), 12'd1);
        chk("chg_right", 12'(c_right - b1), 12'd0);
        run(4'd12, 3); run(4'd2, 6); run(4'd15, 6);
        chk("hi_code_rel", 12'(c_down - b2), 12'd1);

        // frame alignment: event well before the tick
        to_menu();
        chk("fa_menu", 12'(screen), 12'h0);
        run(4'd7, 6); run(4'd0, 10);
        chk("fa_before", 12'(screen), 12'h0);
        tick();
        chk("fa_after", 12'(screen), 12'h1);
        chk("fa_level", 12'(level), 12'h2);

        // frame alignment: state change on the tick edge itself
        to_menu();
        run(4'd8, 5); cyc(4'd8, 1'b1, 1'b0);
        chk("same_tick_scr", 12'(screen), 12'h0);
        chk("same_tick_st", 12'(state_dbg), 12'h1);
        run(4'd0, 6); tick();
        chk("same_next_scr", 12'(screen), 12'h1);
        chk("same_level", 12'(level), 12'h3);

`ifdef SCREEN_CTRL_PAUSE_EN
        run(4'd9, 6); run(4'd0, 6); tick();
        chk("pause_scr", 12'(screen), 12'h2);
        chk("pause_bg", bg_color, 12'h555);
        b0 = c_up;
        run(4'd3, 6); run(4'd0, 6); tick();
        chk("resume_scr", 12'(screen), 12'h1);
        chk("resume_no_up", 12'(c_up - b0), 12'd0);
        run(4'd9, 6); run(4'd0, 6); run(4'd9, 6); run(4'd0, 6); tick();
        chk("pause_menu", 12'(screen), 12'h0);
        chk("pause_level", 12'(level), 12'h3);
`else
        run(4'd9, 6); run(4'd0, 6); tick();
        chk("esc_menu", 12'(screen), 12'h0);
        chk("esc_bg", bg_color, 12'haaa);
`endif

        // randomized traffic
        for (int seg = 0; seg < 400; seg++) begin
            code = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
            len  = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                t = ($urandom_range(0, 7) == 0);
                cyc(4'(code), t, ($urandom_range(0, 299) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/screen_ctrl.md
# screen_ctrl

Menu/game screen sequencer between the keyboard decoder and the VGA drawing pipeline. It consumes the 4-bit key codes produced by the decoder, filters glitches and reduces each key press to a single event. It runs the MENU/GAME/PAUSE state machine and drives level selection, movement pulses and the background colour. Screen changes are committed only on frame boundaries, so a frame never shows two screens.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical samples required before a key code is accepted; range 1..255.
- `clk` in 1: system/pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `key` in 4: decoder code. Values:
  - 0 = released.
  - A = 1, S = 2, W = 3, D = 4.
  - digits 1..4 = 5..8.
  - esc = 9.
  - 10..15 are treated as released.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blanking.
- `screen` out 2: displayed screen. 00 = MENU, 01 = GAME, 10 = PAUSE; 11 never driven.
- `level` out 2: selected level, 0..3.
- `bg_color` out 12: background colour for the current `screen`.
- `game_start` out 1: one-cycle pulse when a game is started.
- `move_up`, `move_down`, `move_left`, `move_right` out 1 each: one-cycle movement pulses.

## Operation
- **Key filter**
  - A code is accepted as `key_stable` after it is sampled identical on `STABLE_CYCLES` consecutive edges.
  - Shorter runs are discarded and the count restarts on any change.
- **Press event**
  - An event fires when `key_stable` goes from released to a valid code (1..9).
  - A change between two non-released codes gives no event; the user must release first.
  - Holding a key gives exactly one event.
- **Arming**
  - After reset, no event fires until a stable released state has been accepted.
  - A key held through reset therefore produces no event.
- **Logical state machine** (internal; changes only on an event)
  - MENU:
    - digit n (codes 5..8) sets `level` = n-1, enters GAME and pulses `game_start`.
    - All other keys are ignored.
  - GAME:
    - W/S/A/D pulse `move_up`/`move_down`/`move_left`/`move_right` respectively.
    - esc goes to PAUSE (see Configuration).
    - Digits are ignored.
  - PAUSE:
    - esc goes to MENU.
    - Any other valid key returns to GAME with no move pulse.
- **Displayed state**
  - On `frame_tick`, `screen` loads the logical state.
  - Several transitions between two ticks show only the last one.
- **Background colour**
  - MENU: 12'haaa.
  - GAME: 12'h3aa.
  - PAUSE: 12'h555.
  - `bg_color` is registered and updates on the same edge as `screen`.
- `level` keeps its value through GAME and PAUSE. It changes only on a digit press in MENU.

## Timing
- **Reset values**
  - `screen` = 00, `level` = 0, `bg_color` = 12'haaa.
  - All pulses = 0.
  - Logical state = MENU, filter count = 0, `key_stable` = released, arming flag = clear.
- **Latency**
  - Let edge 0 be the first edge that samples a new code.
  - The press event is internal after edge `STABLE_CYCLES`.
  - `game_start` and the move pulses are high for exactly one cycle after edge `STABLE_CYCLES+1`.
- **Event and `frame_tick` in the same cycle**
  - The tick commits the pre-event logical state.
  - The new state is displayed at the next tick.
- `frame_tick` is ignored while `rst` is high. Reset mid-operation returns everything to reset values on the next edge.
- Pulses never overlap; at most one output pulse per event.

## Configuration
- Macro `SCREEN_CTRL_PAUSE_EN`.
- **Defined:** esc in GAME goes to PAUSE; PAUSE behaves as described in Operation.
- **Undefined:**
  - esc in GAME goes directly to MENU.
  - PAUSE is unreachable, and `screen` = 10 and `bg_color` = 12'h555 never occur.

## Test plan
- **Reset/arming:** hold `key`=5 through reset release for 20 cycles → no `game_start`, `screen`=00. Release for 4 cycles, then `key`=6 → one `game_start` after edge 5, `level`=1, `screen`=01 at the next `frame_tick`, `bg_color`=12'h3aa.
- **Glitch filter:** `key`=3 for 3 cycles then 0 (STABLE_CYCLES=4) → no `move_up`. `key`=3 for 4 cycles → exactly one `move_up` pulse. Holding 3 for 100 cycles → still one pulse.
- **Code change without release:** in GAME, `key` 1 → 4 directly → one `move_left` only. Codes 10..15 act as released.
- **Frame alignment:** event to GAME 10 cycles before `frame_tick` → `screen` stays 00 until the tick edge. Event in the same cycle as the tick → `screen` stays 00 until the following tick.
- **Pause path, macro defined:** in GAME press esc → `screen`=10, `bg_color`=12'h555. Press W → GAME, no `move_up`. Press esc twice → MENU, `level` unchanged.
- **Pause path, macro undefined:** in GAME press esc → `screen`=00 at the next tick, `bg_color`=12'haaa.
